board_port_arbiter: RTL and testbench
=====================================

# board_port_arbiter

Arbitrates port B of the dual-port board memory (`dmem_valid`) between three requesters: the VGA board reader, the keyboard move writer, and the game-state writer (clocks and winner). It replaces the current address mux and VGA clock gating with a registered, starvation-free scheduler. The scheduler also provides lock support so that multi-word moves are never displayed half-written. It sits between `keyboard_input`, `vga_controller` and the memory, and all of its logic runs on the system clock.

## Interface
- `ADDR_W`, 12, board memory address width
- `DATA_W`, 32, board word width
- `STARVE_LIMIT`, 64, wait cycles after which a writer preempts VGA
- `LOCK_MAX`, 16, maximum cycles a writer lock may be held
- `clock`  in  1  system clock; one clock domain; reset is synchronous and active-high
- `reset`  in  1  synchronous, active-high
- `vga_req` in 1, `vga_addr` in ADDR_W: read request from the VGA reader
- `vga_gnt` out 1: read accepted this cycle
- `vga_rvalid` out 1, `vga_rdata` out DATA_W: read return
- `kb_req` in 1, `kb_addr` in ADDR_W, `kb_wdata` in DATA_W, `kb_lock` in 1: keyboard write request; lock=1 means more words follow
- `kb_ack` out 1: write accepted this cycle
- `gs_req`, `gs_addr`, `gs_wdata`, `gs_lock` (in), `gs_ack` (out): game-state writer, same semantics as the keyboard writer
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1: drive memory port B
- `mem_q` in DATA_W: port B read data
- `lock_err` out 1: one-cycle pulse when a lock is force-released

## Operation
- Each requester holds req, addr, data and lock stable until it sees gnt or ack in the same cycle. At most one gnt or ack is asserted per cycle.
- gnt and ack are combinational from the registered state and the current requests.
- States:
  - ARB: normal arbitration.
  - KB_LOCK: only the keyboard writer may be granted.
  - GS_LOCK: only the game-state writer may be granted.
- Priority in ARB:
  1. A writer whose wait count equals STARVE_LIMIT wins; kb wins if both are starved.
  2. Otherwise, if vga_req is high, VGA wins.
  3. Otherwise the writers alternate round-robin. The rr pointer flips after every writer ack; after reset it points to kb.
- Lock entry: a writer acked in ARB with its lock=1 moves the state to that writer's X_LOCK.
- Lock exit: the locking writer is acked with lock=0, returning to ARB.
- Forced release: the lock cycle count reaches LOCK_MAX. The block pulses lock_err and returns to ARB; the pending word is not acked that cycle.
- In X_LOCK with the locking writer's req low, the cycle is idle (mem_we=0). VGA and the other writer wait.
- Wait counters, one per writer:
  - increment each cycle req=1 and no ack;
  - saturate at STARVE_LIMIT;
  - clear on ack or when req=0.
- Idle cycle (no grant): mem_we=0, and mem_addr and mem_wdata hold their values.
- Ordering: memory accesses occur in grant order. A read granted in the cycle after a write to the same address returns the new data.

## Timing
- Reset values:
  - state ARB, counters 0, rr→kb;
  - mem_addr 0, mem_wdata 0, mem_we 0;
  - vga_rvalid 0, vga_rdata 0, lock_err 0, read pipeline flushed.
- A grant in cycle N registers mem_addr, mem_wdata and mem_we, which are visible in cycle N+1.
- Writes commit at the end of N+1.
- Read latency: vga_rvalid=1 in N+2 with vga_rdata=mem_q captured. vga_rdata holds its value when vga_rvalid=0.
- Back-to-back VGA grants sustain one read per cycle.
- Reset mid-lock or mid-read drops all in-flight operations. No rvalid follows a reset.
- A starvation preemption never occurs inside X_LOCK. The other writer's counter stays saturated and it wins first in ARB.

## Structure
- Package `board_arb_pkg` holds:
  - the state enum (ARB, KB_LOCK, GS_LOCK);
  - requester index constants;
  - default ADDR_W and DATA_W.
- Sub-module `starve_counter`: saturating wait counter with inputs req, ack and limit and output `starved`. It is instantiated twice.
- The read-valid pipeline is a 2-bit shift register inside the top module.

## Test plan
- VGA only, vga_req continuous with addresses 0,1,2 from cycle 0 → gnt every cycle; rvalid in cycles 2,3,4 with mem_q data; mem_we=0 throughout.
- vga_req continuous and kb_req held → kb_ack exactly in the 65th waiting cycle (STARVE_LIMIT=64); mem_we=1 one cycle later; VGA resumes the next cycle.
- kb and gs requesting together with VGA idle → acks alternate kb, gs, kb, gs.
- kb writes addr 10 with lock=1, then addr 11 with lock=0, while vga_req targets 10 → no VGA gnt between the two writes; the first rvalid returns the new value of addr 10.
- gs asserts lock=1 then drops req for 16 cycles → lock_err pulses once at the 16th lock cycle; state returns to ARB; VGA is granted next.
- reset asserted in GS_LOCK with a read in flight → next cycle: mem_we=0, vga_rvalid=0, lock_err=0, and the kb writer is granted first.

Source files
------------

// File: rtl/board_arb_pkg.sv
// board_arb_pkg: shared states, requester indices and default widths for the board port arbiter
package board_arb_pkg;
    typedef enum logic [1:0] {ARB, KB_LOCK, GS_LOCK} arb_state_t;
    localparam int REQ_VGA = 0;
    localparam int REQ_KB = 1;
    localparam int REQ_GS = 2;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/board_port_arbiter_starve_counter.sv
// starve_counter: saturating wait counter that flags a writer waiting limit cycles
module starve_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             ack,
    input  logic [CNT_W-1:0] limit,
    output logic             starved
);
    logic [CNT_W-1:0] count;
    // count waiting cycles, clear when served or when the request goes away
    always_ff @(posedge clock) begin
        if (reset || !req || ack)
            count <= '0;
        else if (count != limit)
            count <= count + 1'b1;
    end
    assign starved = req && (count == limit);
endmodule

// File: rtl/board_port_arbiter.sv
// board_port_arbiter: registered, starvation-free scheduler for board memory port B
module board_port_arbiter
    import board_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 64,
    parameter int LOCK_MAX     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              kb_req,
    input  logic [ADDR_W-1:0] kb_addr,
    input  logic [DATA_W-1:0] kb_wdata,
    input  logic              kb_lock,
    output logic              kb_ack,
    input  logic              gs_req,
    input  logic [ADDR_W-1:0] gs_addr,
    input  logic [DATA_W-1:0] gs_wdata,
    input  logic              gs_lock,
    output logic              gs_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              lock_err
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int LCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [LCK_W-1:0] LOCK_LIMIT = LCK_W'(LOCK_MAX);

    arb_state_t state, next_state;
    logic [2:0] gnt;
    logic [LCK_W-1:0] lock_cnt;
    logic [1:0] rd_pipe;
    logic [DATA_W-1:0] rdata_q;
    logic rr, kb_starved, gs_starved, force_rel;

    starve_counter #(.CNT_W(CNT_W)) u_kb_wait (
        .clock(clock), .reset(reset), .req(kb_req), .ack(gnt[REQ_KB]),
        .limit(LIMIT), .starved(kb_starved)
    );
    starve_counter #(.CNT_W(CNT_W)) u_gs_wait (
        .clock(clock), .reset(reset), .req(gs_req), .ack(gnt[REQ_GS]),
        .limit(LIMIT), .starved(gs_starved)
    );

    // pick at most one requester this cycle and decide lock entry/exit
    always_comb begin
        gnt = '0;
        next_state = state;
        force_rel = 1'b0;
        case (state)
            ARB: begin
                if (kb_starved)
                    gnt[REQ_KB] = 1'b1;
                else if (gs_starved)
                    gnt[REQ_GS] = 1'b1;
                else if (vga_req)
                    gnt[REQ_VGA] = 1'b1;
                else if (kb_req && (!gs_req || !rr))
                    gnt[REQ_KB] = 1'b1;
                else if (gs_req)
                    gnt[REQ_GS] = 1'b1;
                next_state = (gnt[REQ_KB] && kb_lock) ? KB_LOCK :
                             (gnt[REQ_GS] && gs_lock) ? GS_LOCK : ARB;
            end
            KB_LOCK: begin
                force_rel = lock_cnt == LOCK_LIMIT;
                gnt[REQ_KB] = kb_req && !force_rel;
                next_state = (force_rel || (gnt[REQ_KB] && !kb_lock)) ? ARB : KB_LOCK;
            end
            GS_LOCK: begin
                force_rel = lock_cnt == LOCK_LIMIT;
                gnt[REQ_GS] = gs_req && !force_rel;
                next_state = (force_rel || (gnt[REQ_GS] && !gs_lock)) ? ARB : GS_LOCK;
            end
            default: next_state = ARB;
        endcase
    end

    assign vga_gnt = gnt[REQ_VGA];
    assign kb_ack = gnt[REQ_KB];
    assign gs_ack = gnt[REQ_GS];
    assign lock_err = force_rel;

    // scheduler state, round-robin pointer and lock duration (1 in the first locked cycle)
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB;
            rr <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state <= next_state;
            rr <= rr ^ (gnt[REQ_KB] | gnt[REQ_GS]);
            lock_cnt <= (state == ARB) ? LCK_W'(1) : lock_cnt + 1'b1;
        end
    end

    // register the granted access onto port B; idle cycles keep address and data
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_we <= 1'b0;
        end else begin
            mem_we <= gnt[REQ_KB] | gnt[REQ_GS];
            if (|gnt)
                mem_addr <= gnt[REQ_KB] ? kb_addr : gnt[REQ_GS] ? gs_addr : vga_addr;
            if (gnt[REQ_KB] | gnt[REQ_GS])
                mem_wdata <= gnt[REQ_KB] ? kb_wdata : gs_wdata;
        end
    end

    // two-stage read-valid pipeline matching the synchronous memory latency
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pipe <= '0;
            rdata_q <= '0;
        end else begin
            rd_pipe <= {rd_pipe[0], gnt[REQ_VGA]};
            if (rd_pipe[1])
                rdata_q <= mem_q;
        end
    end

    assign vga_rvalid = rd_pipe[1];
    assign vga_rdata = rd_pipe[1] ? mem_q : rdata_q;
endmodule

// File: tb/tb_board_port_arbiter.sv
// tb_board_port_arbiter: directed checks of arbitration, locking, starvation and reset behaviour
module tb_board_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic vga_req = 1'b0, kb_req = 1'b0, gs_req = 1'b0, kb_lock = 1'b0, gs_lock = 1'b0;
    logic [11:0] vga_addr = '0, kb_addr = '0, gs_addr = '0;
    logic [31:0] kb_wdata = '0, gs_wdata = '0;
    logic vga_gnt, vga_rvalid, kb_ack, gs_ack, mem_we, lock_err;
    logic [31:0] vga_rdata, mem_wdata;
    logic [31:0] mem_q = '0;
    logic [11:0] mem_addr;
    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    board_port_arbiter dut (
        .clock(clock), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .kb_req(kb_req), .kb_addr(kb_addr), .kb_wdata(kb_wdata), .kb_lock(kb_lock), .kb_ack(kb_ack),
        .gs_req(gs_req), .gs_addr(gs_addr), .gs_wdata(gs_wdata), .gs_lock(gs_lock), .gs_ack(gs_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .lock_err(lock_err)
    );

    always #5 clock = ~clock;

    // synchronous port-B memory, preloaded with 0xA000_0000 + address during reset
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        mem_q <= mem[mem_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) cyc();
        @(negedge clock);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_rvalid", 32'(vga_rvalid), 0);
        chk("rst_rdata", vga_rdata, 0);
        chk("rst_lock_err", 32'(lock_err), 0);

        // VGA-only stream of three reads
        for (int c = 0; c < 6; c++) begin
            cyc();
            reset = 1'b0;
            vga_req = c < 3;
            vga_addr = 12'(c);
            @(negedge clock);
            chk("vga_gnt", 32'(vga_gnt), 32'(c < 3));
            chk("vga_rvalid", 32'(vga_rvalid), 32'(c >= 2 && c <= 4));
            chk("vga_we", 32'(mem_we), 0);
            if (c >= 2)
                chk("vga_rdata", vga_rdata, 32'hA000_0000 + 32'(c >= 4 ? 2 : c - 2));
        end

        // both writers, VGA idle: round-robin kb, gs, kb, gs
        kb_addr = 12'd30; kb_wdata = 32'h0000_1030;
        gs_addr = 12'd31; gs_wdata = 32'h0000_2031;
        for (int c = 0; c < 6; c++) begin
            cyc();
            kb_req = c < 4;
            gs_req = c < 4;
            @(negedge clock);
            if (c < 4) begin
                chk("rr_kb_ack", 32'(kb_ack), 32'(c % 2 == 0));
                chk("rr_gs_ack", 32'(gs_ack), 32'(c % 2 == 1));
            end
            if (c >= 1) begin
                chk("rr_we", 32'(mem_we), 32'(c <= 4));
                chk("rr_addr", 32'(mem_addr), (c % 2 == 1 && c < 5) ? 30 : 31);
            end
            if (c == 1)
                chk("rr_wdata", mem_wdata, 32'h0000_1030);
        end

        // kb starves behind continuous VGA reads
        vga_addr = 12'd5;
        kb_addr = 12'd20; kb_wdata = 32'hDEAD_0001; kb_lock = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            cyc();
            vga_req = 1'b1;
            kb_req = 1'b1;
            @(negedge clock);
            chk("starve_kb_ack", 32'(kb_ack), 32'(k == 64));
            chk("starve_vga_gnt", 32'(vga_gnt), 32'(k != 64));
        end
        cyc();
        kb_req = 1'b0;
        @(negedge clock);
        chk("starve_we", 32'(mem_we), 1);
        chk("starve_addr", 32'(mem_addr), 20);
        chk("starve_wdata", mem_wdata, 32'hDEAD_0001);
        chk("starve_vga_resume", 32'(vga_gnt), 1);
        cyc();
        vga_req = 1'b0;
        repeat (3) cyc();

        // kb two-word locked move while VGA wants the first word's address
        cyc();
        kb_req = 1'b1; kb_addr = 12'd10; kb_wdata = 32'h1111_0010; kb_lock = 1'b1;
        @(negedge clock);
        chk("lock_first_ack", 32'(kb_ack), 1);
        cyc();
        kb_req = 1'b0;
        vga_req = 1'b1; vga_addr = 12'd10;
        @(negedge clock);
        chk("lock_idle_vga_gnt", 32'(vga_gnt), 0);
        chk("lock_idle_we", 32'(mem_we), 1);
        chk("lock_idle_addr", 32'(mem_addr), 10);
        cyc();
        kb_req = 1'b1; kb_addr = 12'd11; kb_wdata = 32'h2222_0011; kb_lock = 1'b0;
        @(negedge clock);
        chk("lock_last_ack", 32'(kb_ack), 1);
        chk("lock_last_vga_gnt", 32'(vga_gnt), 0);
        chk("lock_last_we", 32'(mem_we), 0);
        cyc();
        kb_req = 1'b0;
        @(negedge clock);
        chk("lock_vga_after", 32'(vga_gnt), 1);
        chk("lock_we2", 32'(mem_we), 1);
        chk("lock_addr2", 32'(mem_addr), 11);
        cyc();
        vga_req = 1'b0;
        @(negedge clock);
        chk("lock_rd_addr", 32'(mem_addr), 10);
        chk("lock_rd_early", 32'(vga_rvalid), 0);
        cyc();
        @(negedge clock);
        chk("lock_rd_valid", 32'(vga_rvalid), 1);
        chk("lock_rd_data", vga_rdata, 32'h1111_0010);

        // gs takes a lock and goes silent: forced release after 16 lock cycles
        cyc();
        gs_req = 1'b1; gs_addr = 12'd40; gs_wdata = 32'h3333_0040; gs_lock = 1'b1;
        @(negedge clock);
        chk("tmo_gs_ack", 32'(gs_ack), 1);
        for (int c = 1; c <= 17; c++) begin
            cyc();
            gs_req = 1'b0;
            vga_req = 1'b1; vga_addr = 12'd3;
            @(negedge clock);
            chk("tmo_lock_err", 32'(lock_err), 32'(c == 16));
            chk("tmo_vga_gnt", 32'(vga_gnt), 32'(c == 17));
            chk("tmo_we", 32'(mem_we), 32'(c == 1));
        end
        cyc();
        vga_req = 1'b0;
        repeat (3) cyc();

        // reset while gs holds the lock
        cyc();
        vga_req = 1'b1; vga_addr = 12'd2;
        @(negedge clock);
        chk("rl_vga_gnt", 32'(vga_gnt), 1);
        cyc();
        vga_req = 1'b0;
        gs_req = 1'b1; gs_addr = 12'd41; gs_wdata = 32'h4444_0041; gs_lock = 1'b1;
        @(negedge clock);
        chk("rl_gs_ack", 32'(gs_ack), 1);
        cyc();
        gs_req = 1'b0;
        kb_req = 1'b1; kb_addr = 12'd50; kb_wdata = 32'h5555_0050; kb_lock = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("rl_kb_blocked", 32'(kb_ack), 0);
        cyc();
        reset = 1'b0;
        gs_req = 1'b1; gs_lock = 1'b0;
        @(negedge clock);
        chk("rl_we", 32'(mem_we), 0);
        chk("rl_addr", 32'(mem_addr), 0);
        chk("rl_rvalid", 32'(vga_rvalid), 0);
        chk("rl_lock_err", 32'(lock_err), 0);
        chk("rl_kb_first", 32'(kb_ack), 1);
        chk("rl_gs_wait", 32'(gs_ack), 0);
        cyc();
        kb_req = 1'b0;
        @(negedge clock);
        chk("rl_gs_next", 32'(gs_ack), 1);
        chk("rl_kb_we", 32'(mem_we), 1);
        chk("rl_kb_addr", 32'(mem_addr), 50);
        cyc();
        gs_req = 1'b0;
        repeat (3) cyc();

        // reset in the middle of a read stream
        cyc();
        vga_req = 1'b1; vga_addr = 12'd1;
        @(negedge clock);
        chk("rr_rd_gnt", 32'(vga_gnt), 1);
        cyc();
        vga_addr = 12'd2;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vga_req = 1'b0;
        @(negedge clock);
        chk("rr_rd_flush1", 32'(vga_rvalid), 0);
        chk("rr_rd_addr", 32'(mem_addr), 0);
        cyc();
        @(negedge clock);
        chk("rr_rd_flush2", 32'(vga_rvalid), 0);
        chk("rr_rd_data", vga_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
